// File: rtl/ps2_key_event_ctrl.sv
// rtl/ps2_key_event_ctrl.sv - PS/2 byte stream to key-event sequencer with FWFT event FIFO
// Tracks E0/F0 prefixes, drops stalled prefixes via watchdog, queues {code, ext, brk}.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    code,
  input  logic                          tick_done,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int WD_W = ($clog2(TIMEOUT_CYC) + 1 > 17) ? $clog2(TIMEOUT_CYC) + 1 : 17;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
  logic              timeout;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [9:0]        mem_d [FIFO_DEPTH];

  logic              is_e0, is_f0, is_err;
  logic              push_req, push_ext, push_brk;
  logic              full, pop, push;
  logic [9:0]        head;

  assign is_e0  = (code == 8'hE0);
  assign is_f0  = (code == 8'hF0);
  assign is_err = (code == 8'h00) || (code == 8'hFF);

  // A byte arriving on the timeout cycle takes precedence over the timeout.
  assign wd_inc  = wd_q + 1'b1;
  assign timeout = (wd_inc == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    push_ext = 1'b0;
    push_brk = 1'b0;
    if (tick_done) begin
      unique case (state_q)
        IDLE: begin
          if (is_e0)       state_d = EXT;
          else if (is_f0)  state_d = BRK;
          else if (!is_err) push_req = 1'b1;
        end
        EXT: begin
          if (is_f0)       state_d = EXT_BRK;
          else if (is_e0)  state_d = EXT;
          else if (is_err) state_d = IDLE;
          else begin
            push_req = 1'b1;
            push_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          if (is_f0)       state_d = BRK;
          else if (is_e0)  state_d = EXT_BRK;
          else if (is_err) state_d = IDLE;
          else begin
            push_req = 1'b1;
            push_brk = 1'b1;
            state_d  = IDLE;
          end
        end
        EXT_BRK: begin
          if (is_e0 || is_f0) state_d = EXT_BRK;
          else if (is_err)    state_d = IDLE;
          else begin
            push_req = 1'b1;
            push_ext = 1'b1;
            push_brk = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timeout) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    wd_d = wd_inc;
    if (tick_done || state_q == IDLE || timeout) wd_d = '0;
  end

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = ev_valid && ev_ready;
  assign push = push_req && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = {code, push_ext, push_brk};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_req && !push) overflow_d = 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head       = mem_q[rd_ptr_q];
  assign ev_valid   = (count_q != '0);
  assign ev_code    = ev_valid ? head[9:2] : 8'h00;
  assign ev_ext     = ev_valid ? head[1] : 1'b0;
  assign ev_brk     = ev_valid ? head[0] : 1'b0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb/tb_ps2_key_event_ctrl.sv - randomized bench for ps2_key_event_ctrl against a prefix-flag model
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TOUT  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code;
  logic       tick_done;
  logic [7:0] ev_code;
  logic       ev_ext, ev_brk, ev_valid, ev_ready;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] mq[$];
  logic       m_ext, m_brk, m_pend, m_ovf;
  int         cyc, last_pref;

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .code(code), .tick_done(tick_done),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [9:0] h;
    h = (mq.size() != 0) ? mq[0] : 10'h000;
    check_eq("ev_valid", ev_valid, (mq.size() != 0));
    check_eq("fifo_count", fifo_count, mq.size());
    check_eq("overflow", overflow, m_ovf);
    check_eq("ev_code", ev_code, h[9:2]);
    check_eq("ev_ext", ev_ext, h[1]);
    check_eq("ev_brk", ev_brk, h[0]);
  endtask

  task automatic model_update(input logic t, input logic [7:0] c, input logic r);
    logic pop, push;
    logic [9:0] ev;
    pop  = (mq.size() != 0) && r;
    push = 1'b0;
    ev   = '0;
    if (t) begin
      if (m_pend && (cyc - last_pref >= TOUT)) begin
        m_ext = 1'b0; m_brk = 1'b0; m_pend = 1'b0;
      end
      if (c == 8'hE0) begin
        m_ext = 1'b1; m_pend = 1'b1; last_pref = cyc;
      end else if (c == 8'hF0) begin
        m_brk = 1'b1; m_pend = 1'b1; last_pref = cyc;
      end else begin
        if (c != 8'h00 && c != 8'hFF) begin
          push = 1'b1;
          ev   = {c, m_ext, m_brk};
        end
        m_ext = 1'b0; m_brk = 1'b0; m_pend = 1'b0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_ovf = 1'b1;
    end
    cyc++;
  endtask

  // Called at a falling edge; returns at the next falling edge after comparing.
  task automatic step(input logic t, input logic [7:0] c, input logic r);
    rst       = 1'b0;
    tick_done = t;
    code      = c;
    ev_ready  = r;
    model_update(t, c, r);
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    tick_done = 1'b0;
    ev_ready  = 1'b0;
    model_clear();
    cyc++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
    check_eq("drain_empty", ev_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tick_done = 1'b0; code = 8'h00; ev_ready = 1'b0;
    cyc = 0; last_pref = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    do_reset();
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_valid", ev_valid, 0);

    // Make code latency
    step(1'b1, 8'h1C, 1'b0);
    check_eq("make_valid", ev_valid, 1);
    check_eq("make_code", ev_code, 8'h1C);
    check_eq("make_flags", {ev_ext, ev_brk}, 2'b00);
    drain();

    // Extended release and plain release
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    check_eq("prefix_no_ev", ev_valid, 0);
    step(1'b1, 8'h75, 1'b0);
    check_eq("xrel_code", ev_code, 8'h75);
    check_eq("xrel_flags", {ev_ext, ev_brk}, 2'b11);
    check_eq("xrel_count", fifo_count, 1);
    drain();
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    check_eq("rel_flags", {ev_code, ev_ext, ev_brk}, {8'h1C, 2'b01});
    drain();

    // Overflow without concurrent pop
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h15 + i), 1'b0);
    check_eq("ovf_count", fifo_count, 4);
    check_eq("ovf_flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf_pop", ev_code, 8'(8'h15 + i));
      step(1'b0, 8'h00, 1'b1);
    end
    check_eq("ovf_empty", ev_valid, 0);

    // Full FIFO with push and pop together
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h15 + i), 1'b0);
    step(1'b1, 8'h19, 1'b1);
    check_eq("pp_count", fifo_count, 4);
    check_eq("pp_ovf", overflow, 0);
    check_eq("pp_head", ev_code, 8'h16);
    drain();

    // Watchdog expiry and near-expiry
    step(1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    check_eq("wd_expired", {ev_code, ev_ext, ev_brk}, {8'h1C, 2'b00});
    drain();
    step(1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    check_eq("wd_alive", {ev_code, ev_ext, ev_brk}, {8'h1C, 2'b01});
    drain();

    // Error code inside a prefix, then reset mid-sequence
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    check_eq("err_flags", {ev_code, ev_ext, ev_brk}, {8'h1C, 2'b00});
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    check_eq("pre_rst_count", fifo_count, 2);
    do_reset();
    check_eq("mid_rst_count", fifo_count, 0);
    check_eq("mid_rst_valid", ev_valid, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    step(1'b1, 8'h1C, 1'b0);
    check_eq("post_rst", {ev_code, ev_ext, ev_brk}, {8'h1C, 2'b00});

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int sel;
      logic [7:0] c;
      sel = int'($urandom_range(0, 99));
      if (sel == 0) begin
        do_reset();
      end else if (sel < 4) begin
        int gap;
        gap = int'($urandom_range(5, 12));
        for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'($urandom));
      end else begin
        int k;
        k = int'($urandom_range(0, 9));
        case (k)
          0, 1:    c = 8'hE0;
          2, 3:    c = 8'hF0;
          4:       c = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
          default: c = 8'($urandom);
        endcase
        step(1'($urandom_range(0, 1)), c, ($urandom_range(0, 2) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequences the decoded PS/2 byte stream into complete key events for the rest of the design. It sits directly after the PS/2 receiver, consuming its `code`/`tick_done` pair, and tracks the E0 (extended) and F0 (break) prefixes. It emits one event per key press or release, carrying code, extended flag and break flag, into a small first-word-fall-through FIFO with a valid/ready handshake toward the consumer. A prefix watchdog drops stalled sequences so a lost byte cannot corrupt the following key.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2
- `TIMEOUT_CYC`, 50000: idle cycles allowed after a prefix byte before the parser returns to IDLE
- `clk`  in  1  system clock
- `rst`  in  1  reset; **synchronous, active-high**
- `code`  in  8  byte from the PS/2 receiver; valid only when `tick_done`=1
- `tick_done`  in  1  one-cycle strobe: `code` holds a new byte
- `ev_code`  out  8  head-entry key code
- `ev_ext`  out  1  head entry preceded by E0
- `ev_brk`  out  1  head entry is a release (preceded by F0)
- `ev_valid`  out  1  FIFO not empty
- `ev_ready`  in  1  consumer accepts the head entry when `ev_valid`=1
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of stored entries
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. It advances only on cycles with `tick_done`=1.
- IDLE:
  - E0 → EXT
  - F0 → BRK
  - 00 or FF → stay, no event (receiver error codes)
  - other → push {code, ext=0, brk=0}
- EXT:
  - F0 → EXT_BRK
  - E0 → stay
  - 00/FF → IDLE, no event
  - other → push {code, 1, 0}, → IDLE
- BRK:
  - F0 → stay
  - E0 → EXT_BRK
  - 00/FF → IDLE, no event
  - other → push {code, 0, 1}, → IDLE
- EXT_BRK:
  - E0/F0 → stay
  - 00/FF → IDLE, no event
  - other → push {code, 1, 1}, → IDLE
- Watchdog counter (≥17 bits):
  - Clears on any `tick_done` and whenever the state is IDLE.
  - Otherwise increments every cycle.
  - When it reaches TIMEOUT_CYC−1 without a byte arriving, the state goes to IDLE and no event is pushed.
- FIFO:
  - Push occurs on the cycle a terminating byte is seen.
  - Pop occurs when `ev_valid && ev_ready`.
  - Head data is combinationally visible on `ev_*` (first-word fall-through).
  - Pointers wrap modulo FIFO_DEPTH.
- Full FIFO with push and no pop: the event is dropped, `overflow`←1, and the stored entries are unchanged.
- Full FIFO with push and pop in the same cycle: both occur, count is unchanged, no overflow.
- Empty FIFO with push (pop impossible): count becomes 1.
- `overflow` clears only on `rst`.

## Timing
- Reset (synchronous, sampled on the `clk` rising edge) takes effect at that edge:
  - state=IDLE, watchdog=0, pointers=0
  - `fifo_count`=0, `ev_valid`=0, `overflow`=0
  - `ev_code`/`ev_ext`/`ev_brk` = 0, forced while the FIFO is empty
- A reset arriving mid-sequence discards any partial prefix and all stored events.
- Latency: a terminating byte with `tick_done` in cycle N → entry written at the end of N → `ev_valid`=1 and `ev_*` valid in N+1.
- Pop in cycle M → the next entry (or `ev_valid`=0) is presented in M+1.
- Back-to-back `tick_done` on consecutive cycles is supported; one byte is processed per cycle.
- Watchdog: last prefix byte in cycle N with no further `tick_done` → state returns to IDLE at the end of cycle N+TIMEOUT_CYC−1. A byte arriving in that same cycle wins: it is processed and the timeout is ignored.

## Test plan
- Make code: bytes 1C → one event {1C, ext=0, brk=0}; `ev_valid` rises exactly 1 cycle after the `tick_done`.
- Extended release: bytes E0, F0, 75 → a single event {75, 1, 1}; no event is produced for the prefix bytes. Also F0, 1C → {1C, 0, 1}.
- Overflow: FIFO_DEPTH=4, `ev_ready`=0, five make codes 15, 16, 17, 18, 19 → `fifo_count`=4 and `overflow`=1. Popping then yields 15, 16, 17, 18, with 19 lost. Repeat with `ev_ready`=1 on the fifth push → no overflow.
- Watchdog: TIMEOUT_CYC=8; send F0, wait 8 cycles, send 1C → event {1C, 0, 0}. Send F0, wait 6 cycles, send 1C → event {1C, 0, 1}.
- Error codes and reset: E0, FF, 1C → {1C, 0, 0}. Assert `rst` for 1 cycle after E0 F0 with two queued events → count 0, `ev_valid`=0, `overflow`=0; a following 1C yields {1C, 0, 0}.
